// File: rtl/cvita_dest_rr_arbiter_pkg.sv
// Shared definitions for the CVITA crossbar output arbiters.
package cvita_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_t;

  // Offset of the input-enable mask register from SR_BASE.
  localparam int SR_ARB_MASK = 0;

endpackage

// File: rtl/cvita_dest_rr_arbiter_if.sv
// Bundle of per-input CVITA streams and the single shared output stream.
interface cvita_dest_rr_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DEST_WIDTH = 4
);
  logic [NUM_INPUTS-1:0][63:0]           i_tdata;
  logic [NUM_INPUTS-1:0]                 i_tlast;
  logic [NUM_INPUTS-1:0]                 i_tvalid;
  logic [NUM_INPUTS-1:0]                 i_tready;
  logic [NUM_INPUTS-1:0][DEST_WIDTH-1:0] i_tdest;
  logic [63:0]                           o_tdata;
  logic                                  o_tlast;
  logic                                  o_tvalid;
  logic                                  o_tready;

  // slave: the arbiter side
  modport slave (
    input  i_tdata, i_tlast, i_tvalid, i_tdest, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  // master: upstream sources plus downstream sink
  modport master (
    output i_tdata, i_tlast, i_tvalid, i_tdest, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/cvita_dest_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module rr_pick #(
  parameter int NUM_INPUTS = 4,
  parameter int LW         = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [LW-1:0]         last,
  output logic                  valid,
  output logic [LW-1:0]         idx,
  output logic [NUM_INPUTS-1:0] onehot
);

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = 1; i <= NUM_INPUTS; i++) begin
      if (!valid && req[(int'(last) + i) % NUM_INPUTS]) begin
        valid = 1'b1;
        idx   = LW'((int'(last) + i) % NUM_INPUTS);
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/cvita_dest_rr_arbiter.sv
// Packet-level round-robin arbiter for one CVITA crossbar output port.
// Grants only inputs whose tdest matches PORT_ID and whose mask bit is set.
module cvita_dest_rr_arbiter
  import cvita_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DEST_WIDTH = 4,
  parameter int PORT_ID    = 0,
  parameter int SR_BASE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  cvita_dest_rr_arbiter_if.slave strm,
  output logic [NUM_INPUTS-1:0] o_grant,
  output logic [31:0]           o_pkt_count
);

  localparam int LW = $clog2(NUM_INPUTS);
  localparam logic [7:0] MASK_ADDR = 8'(SR_BASE + SR_ARB_MASK);

  arb_state_t            state_q, state_d;
  logic [LW-1:0]         sel_q, sel_d;
  logic [LW-1:0]         last_q, last_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic [NUM_INPUTS-1:0] mask_q, mask_d;
  logic [31:0]           cnt_q, cnt_d;

  logic [NUM_INPUTS-1:0] req;
  logic                  pick_vld;
  logic [LW-1:0]         pick_idx;
  logic [NUM_INPUTS-1:0] pick_oh;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_req
    assign req[k] = strm.i_tvalid[k] && (strm.i_tdest[k] == DEST_WIDTH'(PORT_ID)) && mask_q[k];
  end

  rr_pick #(.NUM_INPUTS(NUM_INPUTS), .LW(LW)) u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_vld),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // Data path is a plain mux from the selected input; o_tvalid gates it.
  assign strm.o_tdata = strm.i_tdata[sel_q];
  assign strm.o_tlast = strm.i_tlast[sel_q];
  assign o_grant      = grant_q;
  assign o_pkt_count  = cnt_q;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    grant_d       = grant_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    strm.o_tvalid = 1'b0;
    strm.i_tready = '0;

    if (set_stb && set_addr == MASK_ADDR) mask_d = set_data[NUM_INPUTS-1:0];

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          sel_d   = pick_idx;
          grant_d = pick_oh;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        strm.o_tvalid        = strm.i_tvalid[sel_q];
        strm.i_tready[sel_q] = strm.o_tready;
        if (strm.i_tvalid[sel_q] && strm.o_tready && strm.i_tlast[sel_q]) begin
          last_d  = sel_q;
          grant_d = '0;
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= LW'(NUM_INPUTS - 1);
      grant_q <= '0;
      mask_q  <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
